// File: rtl/hex_page_scheduler.sv
// hex_page_scheduler: arbitrates four nibble sources onto six
// active-low seven-segment digits, auto rotation or manual paging.
// Ports: clk_clk, reset_reset (sync, active-high), src_req[3:0],
//   src_data[95:0], buttons[2:0] (next/prev/freeze, active-low),
//   chave (0 auto, 1 manual), grant[3:0], owner[1:0], hex_out[41:0].
// Optional macro HEX_BLINK_EN: blinks dash and frozen glyphs.
module hex_page_scheduler #(
    parameter int DWELL_CYCLES    = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 12_500_000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [3:0]  src_req,
    input  logic [95:0] src_data,
    input  logic [2:0]  buttons,
    input  logic        chave,
    output logic [3:0]  grant,
    output logic [1:0]  owner,
    output logic [41:0] hex_out
);

    localparam int DWW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DWW-1:0] DWELL_MAX = DWW'(DWELL_CYCLES - 1);
    localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [41:0]    BLANK     = '1;
    localparam logic [41:0]    DASH      = {6{7'b0111111}};

    typedef enum logic [1:0] {
        AUTO_IDLE = 2'd0,
        AUTO_HOLD = 2'd1,
        MANUAL    = 2'd2
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    function automatic logic [41:0] glyphs(input logic [23:0] w);
        logic [41:0] g;
        g = '0;
        for (int d = 0; d < 6; d++) begin
            g[7*d +: 7] = seg7(w[4*d +: 4]);
        end
        return g;
    endfunction

    // First set bit of req scanning upward from start, wrapping.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // Synchronizers: bit 3 = chave, bits 2:0 = buttons (idle high).
    logic [3:0] sync1;
    logic [3:0] sync2;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1 <= 4'b0111;
            sync2 <= 4'b0111;
        end else begin
            sync1 <= {chave, buttons};
            sync2 <= sync1;
        end
    end

    // Debounce: a level is accepted after DEBOUNCE_CYCLES of disagreement.
    logic [DBW-1:0] db_cnt [4];
    logic [3:0]     db_lvl;
    logic [3:0]     db_hit;
    logic [2:0]     ev;

    always_comb begin
        db_hit = '0;
        for (int i = 0; i < 4; i++) begin
            db_hit[i] = (sync2[i] != db_lvl[i]) && (db_cnt[i] == DB_MAX);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
            db_lvl <= 4'b0111;
            ev     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db_lvl[i] || db_hit[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            db_lvl <= db_lvl ^ db_hit;
            // Accepted press is an accepted transition to low.
            ev <= db_hit[2:0] & ~sync2[2:0];
        end
    end

    logic man_sel;
    logic nxt;
    logic prv;
    logic frz;

    assign man_sel = db_lvl[3];
    assign nxt     = ev[0] & ~ev[1];
    assign prv     = ev[1] & ~ev[0];
    assign frz     = ev[2];

    // Arbitration state.
    state_t         state;
    state_t         state_d;
    logic [1:0]     own;
    logic [1:0]     base;
    logic [DWW-1:0] dwell;
    logic           freeze;
    logic [23:0]    snap;
    logic [23:0]    cur_word;
    logic [3:0]     others;
    logic           dwell_sat;
    logic           page_chg;

    assign cur_word  = src_data[24*int'(own) +: 24];
    assign others    = src_req & ~(4'b0001 << own);
    assign dwell_sat = (dwell == DWELL_MAX);
    assign page_chg  = man_sel && ((state != MANUAL) || nxt || prv);
    assign owner     = own;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= AUTO_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (man_sel) begin
            state_d = MANUAL;
        end else begin
            case (state)
                AUTO_IDLE: if (|src_req) state_d = AUTO_HOLD;
                AUTO_HOLD: if (!(|src_req)) state_d = AUTO_IDLE;
                default:   state_d = AUTO_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            own    <= '0;
            base   <= '0;
            dwell  <= '0;
            freeze <= 1'b0;
            snap   <= '0;
        end else if (man_sel) begin
            dwell <= '0;
            if (state != MANUAL) begin
                own    <= (state == AUTO_IDLE) ? 2'd0 : own;
                freeze <= 1'b0;
            end else if (nxt || prv) begin
                own    <= nxt ? own + 2'd1 : own - 2'd1;
                freeze <= 1'b0;
            end else if (frz) begin
                freeze <= ~freeze;
                if (!freeze) begin
                    snap <= cur_word;
                end
            end
        end else begin
            case (state)
                AUTO_IDLE: begin
                    dwell <= '0;
                    if (|src_req) begin
                        own <= rr_pick(src_req, base);
                    end
                end
                AUTO_HOLD: begin
                    if (!src_req[own]) begin
                        dwell <= '0;
                        if (|src_req) begin
                            own <= rr_pick(src_req, own + 2'd1);
                        end else begin
                            base <= own + 2'd1;
                        end
                    end else if (dwell_sat && |others) begin
                        dwell <= '0;
                        own   <= rr_pick(others, own + 2'd1);
                    end else if (!dwell_sat) begin
                        dwell <= dwell + 1'b1;
                    end
                end
                default: begin
                    base   <= own + 2'd1;
                    freeze <= 1'b0;
                    dwell  <= '0;
                end
            endcase
        end
    end

    // Blink phase: on for BLINK_CYCLES, then blank for BLINK_CYCLES.
    logic show_on;

`ifdef HEX_BLINK_EN
    localparam int BLW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLW-1:0] BLINK_MAX = BLW'(BLINK_CYCLES - 1);

    logic [BLW-1:0] blink_cnt;
    logic           blink_off;

    always_ff @(posedge clk_clk) begin
        if (reset_reset || page_chg) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign show_on = ~blink_off;
`else
    logic unused_blink;
    assign unused_blink = ^BLINK_CYCLES ^ page_chg;
    assign show_on      = 1'b1;
`endif

    // Outputs: grant from registered state, segments registered below.
    logic [41:0] hex_d;

    always_comb begin
        grant = '0;
        hex_d = BLANK;
        case (state)
            AUTO_HOLD: begin
                grant = 4'b0001 << own;
                hex_d = glyphs(cur_word);
            end
            MANUAL: begin
                if (src_req[own]) begin
                    grant = 4'b0001 << own;
                end
                if (freeze) begin
                    hex_d = show_on ? glyphs(snap) : BLANK;
                end else if (src_req[own]) begin
                    hex_d = glyphs(cur_word);
                end else begin
                    hex_d = show_on ? DASH : BLANK;
                end
            end
            default: begin
                grant = '0;
                hex_d = BLANK;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            hex_out <= BLANK;
        end else begin
            hex_out <= hex_d;
        end
    end

endmodule

// File: tb/tb_hex_page_scheduler.sv
// tb_hex_page_scheduler: random auto-mode traffic against a
// reference arbiter, plus directed manual, freeze and reset steps.
module tb_hex_page_scheduler;

    localparam int DWELL = 8;
    localparam int DEB   = 4;
    localparam int BLINK = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [95:0] sd  = '0;
    logic [2:0]  btn = 3'b111;
    logic        chv = 1'b0;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [41:0] hex;

    int n_tests = 0;
    int n_fail  = 0;

    hex_page_scheduler #(
        .DWELL_CYCLES(DWELL),
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES(BLINK)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .src_req(req),
        .src_data(sd),
        .buttons(btn),
        .chave(chv),
        .grant(grant),
        .owner(owner),
        .hex_out(hex)
    );

    always #5 clk = ~clk;

    logic [6:0] seg [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [41:0] DASH = {6{7'b0111111}};
    localparam logic [41:0] BLNK = '1;

    function automatic logic [41:0] glyphs(input logic [23:0] w);
        logic [41:0] g;
        g = '0;
        for (int d = 0; d < 6; d++) begin
            g[7*d +: 7] = seg[w[4*d +: 4]];
        end
        return g;
    endfunction

    function automatic logic [23:0] word(input int s);
        return sd[24*s +: 24];
    endfunction

    // Reference: who holds the display and for how long.
    bit          m_busy;
    int          m_own;
    int          m_held;
    int          m_next;
    logic [3:0]  m_grant;
    logic [41:0] m_hex;

    function automatic int first_from(input logic [3:0] r, input int s);
        for (int i = 0; i < 4; i++) begin
            if (r[(s + i) % 4]) return (s + i) % 4;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_own   = 0;
        m_held  = 0;
        m_next  = 0;
        m_grant = '0;
        m_hex   = BLNK;
    endtask

    task automatic model_step();
        logic [3:0] rest;
        m_hex = m_busy ? glyphs(word(m_own)) : BLNK;
        rest  = req;
        rest[m_own] = 1'b0;
        if (!m_busy) begin
            if (req != 0) begin
                m_busy = 1;
                m_own  = first_from(req, m_next);
                m_held = 1;
            end
        end else if (!req[m_own]) begin
            if (req != 0) begin
                m_own  = first_from(req, (m_own + 1) % 4);
                m_held = 1;
            end else begin
                m_busy = 0;
                m_next = (m_own + 1) % 4;
            end
        end else if (m_held >= DWELL && rest != 0) begin
            m_own  = first_from(rest, (m_own + 1) % 4);
            m_held = 1;
        end else begin
            m_held++;
        end
        m_grant = m_busy ? 4'(1 << m_own) : 4'b0;
    endtask

    task automatic chk(input string tag, input logic [41:0] got,
                       input logic [41:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [3:0] r);
        req = r;
        model_step();
        tick(1);
        chk("auto_grant", 42'(grant), 42'(m_grant));
        chk("auto_owner", 42'(owner), 42'(m_own));
        chk("auto_hex", hex, m_hex);
    endtask

    task automatic rand_run(input int n);
        logic [3:0] r;
        r = req;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(5) == 0) r = 4'($urandom);
            if ($urandom_range(2) == 0) begin
                sd = {$urandom(), $urandom(), $urandom()};
            end
            cyc(r);
        end
    endtask

    task automatic press(input logic [2:0] m);
        btn = ~m;
        tick(10);
        btn = 3'b111;
        tick(10);
    endtask

    initial begin
        model_reset();
        tick(3);
        chk("rst_grant", 42'(grant), 42'd0);
        chk("rst_owner", 42'(owner), 42'd0);
        chk("rst_hex", hex, BLNK);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) cyc(4'b0000);
        chk("idle_hex", hex, BLNK);

        sd[23:0]  = 24'h012345;
        sd[71:48] = 24'hABCDEF;
        cyc(4'b0101);
        chk("first_grant", 42'(grant), 42'b0001);
        cyc(4'b0101);
        chk("first_hex", hex, glyphs(24'h012345));
        repeat (6) cyc(4'b0101);
        chk("dwell_hold", 42'(grant), 42'b0001);
        cyc(4'b0101);
        chk("dwell_rot", 42'(grant), 42'b0100);
        repeat (8) cyc(4'b0101);
        chk("dwell_back", 42'(grant), 42'b0001);
        repeat (8) cyc(4'b0101);
        chk("dwell_to2", 42'(grant), 42'b0100);
        cyc(4'b0001);
        chk("drop_to0", 42'(grant), 42'b0001);
        cyc(4'b0000);
        chk("drop_idle", 42'(grant), 42'd0);
        cyc(4'b0000);
        chk("drop_blank", hex, BLNK);

        rand_run(300);
        cyc(4'b0000);
        cyc(4'b0000);

        chv = 1'b1;
        tick(10);
        chk("man_page0", 42'(owner), 42'd0);
        chk("man_nogrant", 42'(grant), 42'd0);
        chk("man_dash0", hex, DASH);
        sd[23:0] = 24'h012345;
        req = 4'b0001;
        tick(3);
        chk("man_grant0", 42'(grant), 42'b0001);
        chk("man_hex0", hex, glyphs(24'h012345));
        press(3'b001);
        chk("next_once", 42'(owner), 42'd1);
        chk("man_dash1", hex, DASH);
        btn = 3'b110;
        tick(2);
        btn = 3'b111;
        tick(10);
        chk("glitch", 42'(owner), 42'd1);
        press(3'b011);
        chk("next_prev", 42'(owner), 42'd1);

        sd[47:24] = 24'h000777;
        tick(1);
        press(3'b100);
        chk("frz_show", hex, glyphs(24'h000777));
        sd[47:24] = 24'hFFFFFF;
        tick(3);
        chk("frz_hold", hex, glyphs(24'h000777));
        req = 4'b0011;
        tick(3);
        chk("frz_grant", 42'(grant), 42'b0010);
        chk("frz_req", hex, glyphs(24'h000777));
        press(3'b010);
        chk("prev_page", 42'(owner), 42'd0);
        chk("prev_unfrz", hex, glyphs(24'h012345));
        chk("prev_grant", 42'(grant), 42'b0001);

        press(3'b001);
        req = 4'b0000;
        chv = 1'b0;
        tick(10);
        chk("leave_grant", 42'(grant), 42'd0);
        chk("leave_blank", hex, BLNK);
        req = 4'b1111;
        tick(1);
        chk("leave_rr", 42'(grant), 42'b0100);
        chk("leave_own", 42'(owner), 42'd2);

        req = 4'b0100;
        chv = 1'b1;
        tick(10);
        chk("reman_page", 42'(owner), 42'd2);
        press(3'b100);
        chk("refrz", hex, glyphs(word(2)));
        chv = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        chk("rst2_grant", 42'(grant), 42'd0);
        chk("rst2_owner", 42'(owner), 42'd0);
        chk("rst2_hex", hex, BLNK);
        rst = 1'b0;
        model_reset();
        cyc(4'b1111);
        chk("rst2_rr0", 42'(grant), 42'b0001);
        cyc(4'b1111);
        chk("rst2_show", hex, glyphs(word(0)));

        rand_run(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
